// File: rtl/sr595_chain_driver_if.sv
// Parallel-word handshake between the core-side register
// and the 74x595 chain driver.
interface sr595_chain_driver_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/sr595_chain_driver.sv
// Serial driver for a daisy-chain of 74x595 shift registers:
// shifts a word out MSB first, latches it, handles power-up clear.
module sr595_chain_driver #(
  parameter int CHIPS   = 2,
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  sr595_chain_driver_if.slave bus,
  output logic                ser,
  output logic                srclk,
  output logic                rclk,
  output logic                srclr_n,
  output logic                oe_n
);
  localparam int W  = 8 * CHIPS;
  localparam int CW = $clog2(W + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    CLR,
    CLR_LATCH,
    CLR_GAP,
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] div, div_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  sreg, sreg_d;
  logic          ser_d, srclk_d, rclk_d;
  logic          srclr_n_d, oe_n_d, ready_d;
  logic          tick;

  assign tick = (div == DIV_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLR;
      div       <= '0;
      cnt       <= '0;
      sreg      <= '0;
      ser       <= 1'b0;
      srclk     <= 1'b0;
      rclk      <= 1'b0;
      srclr_n   <= 1'b0;
      oe_n      <= 1'b1;
      bus.ready <= 1'b0;
    end else begin
      state     <= state_d;
      div       <= div_d;
      cnt       <= cnt_d;
      sreg      <= sreg_d;
      ser       <= ser_d;
      srclk     <= srclk_d;
      rclk      <= rclk_d;
      srclr_n   <= srclr_n_d;
      oe_n      <= oe_n_d;
      bus.ready <= ready_d;
    end
  end

  always_comb begin
    state_d = state;
    div_d   = tick ? '0 : DW'(div + 1'b1);
    cnt_d   = cnt;
    sreg_d  = sreg;
    unique case (state)
      CLR:       if (tick) state_d = CLR_LATCH;
      CLR_LATCH: if (tick) state_d = CLR_GAP;
      CLR_GAP:   if (tick) state_d = IDLE;
      IDLE: begin
        div_d = '0;
        if (bus.valid && bus.ready) begin
          sreg_d  = bus.data;
          cnt_d   = CW'(W);
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO:  if (tick) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (tick) begin
          sreg_d  = {sreg[W-2:0], 1'b0};
          cnt_d   = cnt - 1'b1;
          state_d = (cnt == CW'(1)) ? LATCH : SHIFT_LO;
        end
      end
      LATCH:     if (tick) state_d = GAP;
      GAP:       if (tick) state_d = IDLE;
      default:   state_d = CLR;
    endcase

    // Outputs are registered from the next state so they align with it.
    ser_d     = (state_d == SHIFT_LO) ? sreg_d[W-1] : ser;
    srclk_d   = (state_d == SHIFT_HI);
    rclk_d    = (state_d == CLR_LATCH) || (state_d == LATCH);
    srclr_n_d = (state_d != CLR);
    oe_n_d    = oe_n && (state_d != IDLE);
    ready_d   = (state_d == IDLE);
  end
endmodule

// File: tb/tb_sr595_chain_driver.sv
// Scoreboard bench: a 74x595 chain model checks every latched word
// and the SRCLK rise count behind it.
module tb_sr595_chain_driver;
  typedef struct {
    logic [15:0] word;
    int          rises;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rst1;
  logic ser0, srclk0, rclk0, srclr_n0, oe_n0;
  logic ser1, srclk1, rclk1, srclr_n1, oe_n1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  sr595_chain_driver_if #(.W(16)) b0 ();
  sr595_chain_driver_if #(.W(8))  b1 ();

  sr595_chain_driver #(.CHIPS(2), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave),
    .ser(ser0), .srclk(srclk0), .rclk(rclk0),
    .srclr_n(srclr_n0), .oe_n(oe_n0)
  );

  sr595_chain_driver #(.CHIPS(1), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1.slave),
    .ser(ser1), .srclk(srclk1), .rclk(rclk1),
    .srclr_n(srclr_n1), .oe_n(oe_n1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Chain model and monitor for the 2-chip instance
  logic [15:0] sh0 = '0;
  logic        ps0 = 1'b0, pr0 = 1'b0;
  int          rises0 = 0;

  always @(negedge clk) begin
    ps0 <= srclk0;
    pr0 <= rclk0;
    if (!srclr_n0) sh0 <= '0;
    else if (srclk0 && !ps0) sh0 <= {sh0[14:0], ser0};
    if (rst) rises0 <= 0;
    else if (srclk0 && !ps0) rises0 <= rises0 + 1;
    if (rclk0 && !pr0) begin
      rises0 <= 0;
      if (sb0.size() == 0) begin
        chk("latch0_unexpected", 32'(sh0), 32'hFFFF_FFFF);
      end else begin
        chk("chain0", 32'(sh0), 32'(sb0[0].word));
        chk("rises0", rises0, sb0[0].rises);
        void'(sb0.pop_front());
      end
    end
  end

  // Chain model and monitor for the 1-chip instance
  logic [7:0] sh1 = '0;
  logic       ps1 = 1'b0, pr1 = 1'b0;
  int         rises1 = 0;

  always @(negedge clk) begin
    ps1 <= srclk1;
    pr1 <= rclk1;
    if (!srclr_n1) sh1 <= '0;
    else if (srclk1 && !ps1) sh1 <= {sh1[6:0], ser1};
    if (rst1) rises1 <= 0;
    else if (srclk1 && !ps1) rises1 <= rises1 + 1;
    if (rclk1 && !pr1) begin
      rises1 <= 0;
      if (sb1.size() == 0) begin
        chk("latch1_unexpected", 32'(sh1), 32'hFFFF_FFFF);
      end else begin
        chk("chain1", 32'(sh1), 32'(sb1[0].word));
        chk("rises1", rises1, sb1[0].rises);
        void'(sb1.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] w, input bit hold,
                      input logic [15:0] nxt, input bit noise);
    int n;
    b0.data  = w;
    b0.valid = 1'b1;
    n = 0;
    while (!b0.ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 500), 1);
    sb0.push_back(exp_t'{w, 16});
    @(negedge clk);
    chk("accept", 32'(b0.ready), 0);
    b0.data  = hold ? nxt : w;
    b0.valid = hold;
    n = 0;
    while (!b0.ready && n < 500) begin
      if (noise) begin
        b0.data  = 16'h1234;
        b0.valid = (n >= 10 && n < 40);
      end
      @(negedge clk);
      n++;
    end
    chk("latency", n, 68);
  endtask

  logic [3:0] clr_tab [6] = '{4'b0010, 4'b1110, 4'b1110,
                              4'b1010, 4'b1010, 4'b1001};

  initial begin
    int n;
    logic [15:0] pat;
    rst      = 1'b1;
    rst1     = 1'b1;
    b0.data  = '0;
    b0.valid = 1'b1;
    b1.data  = '0;
    b1.valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_vals",
        32'({ser0, srclk0, rclk0, srclr_n0, oe_n0, b0.ready}),
        32'(6'b000010));

    // Power-up clear; VALID held high must not be accepted
    sb0.push_back(exp_t'{16'h0000, 0});
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("clr_seq", 32'({srclr_n0, rclk0, oe_n0, b0.ready}),
          32'(clr_tab[i]));
    end
    b0.valid = 1'b0;

    send(16'hA5C3, 1'b0, 16'h0000, 1'b0);
    send(16'hFFFF, 1'b1, 16'h0001, 1'b0);
    send(16'h0001, 1'b0, 16'h0000, 1'b0);
    send(16'h00FF, 1'b0, 16'h0000, 1'b1);

    // Reset in the middle of a transfer
    b0.data  = 16'hBEEF;
    b0.valid = 1'b1;
    @(negedge clk);
    b0.valid = 1'b0;
    n = 0;
    while (rises0 < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rise5_wait", rises0, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs",
        32'({srclk0, rclk0, oe_n0, b0.ready, srclr_n0}),
        32'(5'b00100));
    sb0.delete();
    sb0.push_back(exp_t'{16'h0000, 0});
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!b0.ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("re_clr_len", n, 6);
    chk("re_oe_n", 32'(oe_n0), 0);

    // Narrow chain, undivided clock
    sb1.push_back(exp_t'{16'h0000, 0});
    rst1 = 1'b0;
    n = 0;
    while (!b1.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clr1_len", n, 3);
    b1.data  = 8'h81;
    b1.valid = 1'b1;
    sb1.push_back(exp_t'{16'h0081, 8});
    @(negedge clk);
    b1.valid = 1'b0;
    chk("accept1", 32'(b1.ready), 0);
    pat = '0;
    n = 0;
    while (!b1.ready && n < 100) begin
      if (n < 16) pat = {pat[14:0], srclk1};
      @(negedge clk);
      n++;
    end
    chk("latency1", n, 18);
    chk("srclk1_pattern", 32'(pat), 32'h5555);

    n = 0;
    while ((sb0.size() + sb1.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", sb0.size() + sb1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
